// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : fetch_unit
// Function : PC-owning instruction fetch with hold, branch redirect and HALT
// Revision : 1.0
// ============================================================================
module fetch_unit #(
  parameter int                     PC_WIDTH    = 8,
  parameter int                     INSTR_WIDTH = 9,
  parameter logic [INSTR_WIDTH-1:0] HALT_WORD   = '1
) (
  input  logic                   clock,
  input  logic                   resetN,
  input  logic                   start,
  input  logic                   nextIns,
  input  logic                   branchTaken,
  input  logic [PC_WIDTH-1:0]    branchTarget,
  output logic                   instrReq,
  output logic [PC_WIDTH-1:0]    instrAddr,
  input  logic [INSTR_WIDTH-1:0] instrData,
  output logic [2:0]             instructions,
  output logic [INSTR_WIDTH-4:0] operand,
  output logic [PC_WIDTH-1:0]    pc,
  output logic                   instrValid,
  output logic                   done
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FETCH   = 3'd1,
    S_CAPTURE = 3'd2,
    S_HOLD    = 3'd3,
    S_HALTED  = 3'd4
  } state_t;

  state_t                   r_state;
  logic                     r_req;
  logic [PC_WIDTH-1:0]      r_addr;
  logic [PC_WIDTH-1:0]      r_pc;
  logic [2:0]               r_opcode;
  logic [INSTR_WIDTH-4:0]   r_operand;
  logic                     r_valid;
  logic                     r_done;

  logic [PC_WIDTH-1:0]      w_next_pc;

  // Sequential step wraps naturally at the PC width.
  assign w_next_pc = branchTaken ? branchTarget : (r_pc + PC_WIDTH'(1));

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      r_state   <= S_IDLE;
      r_req     <= 1'b0;
      r_addr    <= '0;
      r_pc      <= '0;
      r_opcode  <= '0;
      r_operand <= '0;
      r_valid   <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state <= S_FETCH;
            r_req   <= 1'b1;
            r_addr  <= r_pc;
          end
        end
        S_FETCH: begin
          r_state <= S_CAPTURE;
          r_req   <= 1'b0;
        end
        S_CAPTURE: begin
          // HALT leaves the previous instruction visible but unqualified.
          if (instrData == HALT_WORD) begin
            r_state <= S_HALTED;
            r_done  <= 1'b1;
          end else begin
            r_opcode  <= instrData[INSTR_WIDTH-1 -: 3];
            r_operand <= instrData[INSTR_WIDTH-4:0];
            r_valid   <= 1'b1;
            r_state   <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (nextIns) begin
            r_pc    <= w_next_pc;
            r_addr  <= w_next_pc;
            r_req   <= 1'b1;
            r_valid <= 1'b0;
            r_state <= S_FETCH;
          end
        end
        S_HALTED: begin
          r_state <= S_HALTED;
        end
        default: begin
          r_state   <= S_IDLE;
          r_req     <= 1'b0;
          r_addr    <= '0;
          r_pc      <= '0;
          r_opcode  <= '0;
          r_operand <= '0;
          r_valid   <= 1'b0;
          r_done    <= 1'b0;
        end
      endcase
    end
  end

  assign instrReq     = r_req;
  assign instrAddr    = r_addr;
  assign pc           = r_pc;
  assign instructions = r_opcode;
  assign operand      = r_operand;
  assign instrValid   = r_valid;
  assign done         = r_done;

endmodule
`default_nettype wire
